imem_boot_loader: RTL
=====================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256: instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port byte_in, input, 8 bits: serial program stream byte.
REQ-005 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid this cycle.
REQ-006 The block SHALL have port byte_ready, output, 1 bit: the loader accepts byte_in this cycle.
REQ-007 The block SHALL have port reload, input, 1 bit: restart loading; sampled only in DONE or ERR.
REQ-008 The block SHALL have port imem_we, output, 1 bit: instruction memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: byte address of the write, always word-aligned.
REQ-010 The block SHALL have port imem_wdata, output, 32 bits: word to write.
REQ-011 The block SHALL have port core_reset, output, 1 bit: drives the core reset input.
REQ-012 The block SHALL have port load_done, output, 1 bit: program loaded, core running.
REQ-013 The block SHALL have port load_err, output, 1 bit: header word count out of range.

Function
REQ-014 A byte SHALL transfer on a rising edge where byte_valid and byte_ready are both 1; byte_in is ignored otherwise.
REQ-015 The FSM SHALL have exactly six states: HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-016 The stream format SHALL be: a 16-bit word count N, low byte first, then N words of 4 bytes each, little-endian.
REQ-017 In HDR0, byte_ready SHALL be 1; a transfer SHALL latch N[7:0] and move to HDR1.
REQ-018 In HDR1, byte_ready SHALL be 1; a transfer SHALL latch N[15:8].
REQ-019 On that HDR1 transfer, the next state SHALL be DONE if N==0, ERR if N>DEPTH_WORDS, and DATA otherwise.
REQ-020 In DATA, byte_ready SHALL be 1.
REQ-021 In DATA, each transfer SHALL place the byte into lane k of the word shift register, where k is a 2-bit byte counter (lane 0 = bits 7:0).
REQ-022 On the 4th byte of a word (k==3), the FSM SHALL move to WRITE, with k wrapping to 0.
REQ-023 In WRITE, byte_ready SHALL be 0 and imem_we SHALL be 1 for exactly one cycle.
REQ-024 In WRITE, imem_addr SHALL equal word_idx*4 and imem_wdata SHALL be the assembled word.
REQ-025 After WRITE, word_idx SHALL increment; the next state SHALL be DONE if word_idx+1==N, else DATA.
REQ-026 Throughput SHALL be at most one word per 5 cycles: 4 byte cycles plus 1 WRITE cycle.
REQ-027 Stalls (byte_valid=0) SHALL hold all state; there SHALL be no timeout.
REQ-028 imem_we SHALL be 0 in every state except WRITE.
REQ-029 imem_addr and imem_wdata SHALL hold their last values when imem_we is 0.
REQ-030 core_reset SHALL be 1 in every state except DONE; it SHALL drop the cycle after entering DONE.
REQ-031 load_done SHALL be 1 exactly in DONE, and load_err exactly in ERR.
REQ-032 In DONE or ERR, byte_ready SHALL be 0.
REQ-033 In DONE or ERR, reload=1 SHALL move to HDR0 next cycle, clearing word_idx, k, N and load_err, and reasserting core_reset.
REQ-034 reload SHALL be ignored in HDR0, HDR1, DATA and WRITE.
REQ-035 A reload coinciding with byte_valid in DONE SHALL not consume that byte.
REQ-036 Words already written before a reload SHALL not be cleared in memory.

Reset
REQ-037 While reset is 1, the FSM SHALL be forced asynchronously to HDR0.
REQ-038 While reset is 1, word_idx, k, N and the shift register SHALL be 0.
REQ-039 While reset is 1, outputs SHALL be: imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_err=0, byte_ready=0.
REQ-040 byte_ready SHALL rise on the first clock edge after reset deasserts.
REQ-041 Reset asserted mid-load, including during WRITE, SHALL abort immediately with no further imem_we pulse; a partial word SHALL be discarded.

Verification
REQ-042 Stream 02 00 13 00 00 00 93 00 10 00 SHALL produce writes (0x0, 0x00000013) and (0x4, 0x00100093).
REQ-043 After that stream, load_done SHALL be 1 and core_reset SHALL be 0.
REQ-044 Header 00 00 SHALL produce DONE with no imem_we pulse.
REQ-045 Header 01 01 (N=257) with DEPTH_WORDS=256 SHALL produce ERR: load_err=1, core_reset=1, byte_ready=0, no writes.
REQ-046 byte_valid toggled randomly SHALL produce write data and addresses identical to the back-to-back stream.
REQ-046a byte_valid held high through WRITE SHALL cause no byte to be lost.
REQ-047 Reset asserted after the 2nd data byte SHALL give imem_we=0 and HDR0.
REQ-047a After that reset, a fresh full stream SHALL load correctly.
REQ-048 A reload pulse in DONE SHALL reassert core_reset next cycle.
REQ-048a After that reload, a new 1-word stream SHALL write address 0x0.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Bundles the loader's byte-stream handshake, reload request, instruction
//   memory write port and core/status outputs.
//   Signals:
//     byte_in[7:0], byte_valid -> loader   program stream byte and its valid
//     byte_ready               <- loader   loader accepts byte_in this cycle
//     reload                   -> loader   restart loading (DONE/ERR only)
//     imem_we, imem_addr[31:0],
//     imem_wdata[31:0]         <- loader   instruction memory write port
//     core_reset               <- loader   holds the core in reset
//     load_done, load_err      <- loader   load status
//   Modports: slave = loader side, master = stream source / system side.
interface imem_boot_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    modport slave (
        input  byte_in, byte_valid, reload,
        output byte_ready, imem_we, imem_addr, imem_wdata,
               core_reset, load_done, load_err
    );

    modport master (
        output byte_in, byte_valid, reload,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
               core_reset, load_done, load_err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program over a byte stream (16-bit little-endian word count N,
//   then N little-endian 32-bit words), writes each word into instruction
//   memory at consecutive word-aligned byte addresses, then releases the core
//   from reset. Out-of-range N (> DEPTH_WORDS) ends in an error state.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    imem_boot_loader_if.slave (stream in, imem write port, status)
//   Parameter:
//     DEPTH_WORDS  instruction memory capacity in 32-bit words
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,
    imem_boot_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    // Keeps byte_ready low until the first clock edge after reset release.
    logic        armed_q, armed_d;

    logic        ready;
    logic        xfer;
    logic [15:0] n_hdr;
    logic [31:0] word_next;

    always_comb begin
        ready = armed_q && ((state_q == HDR0) || (state_q == HDR1) ||
                            (state_q == DATA));
        xfer  = bus.byte_valid && ready;
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        k_d        = k_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        armed_d    = 1'b1;

        n_hdr     = {bus.byte_in, n_q[7:0]};
        word_next = shift_q;
        word_next[{k_q, 3'b000} +: 8] = bus.byte_in;

        case (state_q)
            HDR0: begin
                if (xfer) begin
                    n_d[7:0] = bus.byte_in;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    n_d = n_hdr;
                    if (n_hdr == '0) begin
                        state_d = DONE;
                    end else if (32'(n_hdr) > DEPTH_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shift_d = word_next;
                    k_d     = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Write port registers load here so they hold their
                        // value outside the single WRITE cycle.
                        state_d = WRITE;
                        addr_d  = {14'b0, word_idx_q, 2'b00};
                        wdata_d = word_next;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == n_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            DONE, ERR: begin
                if (bus.reload) begin
                    state_d    = HDR0;
                    word_idx_d = '0;
                    k_d        = '0;
                    n_d        = '0;
                    shift_d    = '0;
                end
            end
            default: begin
                state_d = HDR0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HDR0;
            n_q        <= '0;
            word_idx_q <= '0;
            k_q        <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        bus.byte_ready = ready;
        bus.imem_we    = (state_q == WRITE);
        bus.imem_addr  = addr_q;
        bus.imem_wdata = wdata_q;
        bus.core_reset = (state_q != DONE);
        bus.load_done  = (state_q == DONE);
        bus.load_err   = (state_q == ERR);
    end

endmodule
